// File: rtl/vend_pkg.sv
// vend_pkg -- shared types and constants for the vending controller.
//   state_t    : FSM state encoding, also driven out on vend_ctrl.state
//   NICKEL_U   : credit units for a nickel
//   DIME_U     : credit units for a dime
//   CREDIT_MAX : largest credit the 5-bit credit register can hold
//   price_u()  : item price in credit units from the 2-bit cost code
package vend_pkg;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    MONEY     = 3'd1,
    PURCHASED = 3'd2,
    REJECTION = 3'd3,
    REFUND    = 3'd4
  } state_t;

  localparam logic [4:0] NICKEL_U   = 5'd1;
  localparam logic [4:0] DIME_U     = 5'd2;
  localparam logic [4:0] CREDIT_MAX = 5'd31;

  // 5*(cost+1) as shift-and-add; the largest result (20) fits in 5 bits.
  function automatic logic [4:0] price_u(input logic [1:0] cost);
    logic [4:0] c1;
    c1 = {3'b000, cost} + 5'd1;
    return (c1 << 2) + c1;
  endfunction

endpackage

// File: rtl/vend_ctrl_hold_timer.sv
// hold_timer -- down-counter giving the dwell time of the PURCHASED and
// REJECTION states.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears the counter
//   load  : one-cycle pulse, loads count
//   count : number of cycles to hold (must be >= 1 when loaded)
//   done  : high during the last held cycle (terminal count = 1)
module hold_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] count,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= count;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Loaded with N on the edge that enters the hold state, so the state sees
  // N, N-1, .. 1 and leaves after exactly N cycles.
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl -- coin-operated vending controller.
//   Parameters : PURCH_CYCLES (PURCHASED hold), REJ_CYCLES (REJECTION hold)
//   Inputs     : clk, rst_n (async, active-low), nickel, dime, sel_valid,
//                cost[1:0], foodtype[1:0], refund_req, coin_ready
//   Outputs    : state[2:0], credit[4:0], vend, vend_type[1:0],
//                change_nickel, coin_reject
//   Build option: define VEND_AUTO_CHANGE_EN to pay out remaining credit
//   automatically after a purchase instead of returning to MONEY.
//
// state      | meaning
// INIT       | no credit, waiting for a coin
// MONEY      | credit held, waiting for selection or refund
// PURCHASED  | item dispensed, holding PURCH_CYCLES
// REJECTION  | selection refused, holding REJ_CYCLES
// REFUND     | paying credit back one nickel per hopper handshake
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PURCH_CYCLES = 100,
  parameter int REJ_CYCLES   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nickel,
  input  logic       dime,
  input  logic       sel_valid,
  input  logic [1:0] cost,
  input  logic [1:0] foodtype,
  input  logic       refund_req,
  input  logic       coin_ready,
  output logic [2:0] state,
  output logic [4:0] credit,
  output logic       vend,
  output logic [1:0] vend_type,
  output logic       change_nickel,
  output logic       coin_reject
);

  localparam int HOLD_MAX = (PURCH_CYCLES > REJ_CYCLES) ? PURCH_CYCLES : REJ_CYCLES;
  localparam int HOLD_W   = ($clog2(HOLD_MAX + 1) < 1) ? 1 : $clog2(HOLD_MAX + 1);
  // A zero hold would never reach terminal count; treat it as one cycle.
  localparam logic [HOLD_W-1:0] PURCH_LD = (PURCH_CYCLES < 1) ? HOLD_W'(1) : HOLD_W'(PURCH_CYCLES);
  localparam logic [HOLD_W-1:0] REJ_LD   = (REJ_CYCLES < 1) ? HOLD_W'(1) : HOLD_W'(REJ_CYCLES);

`ifdef VEND_AUTO_CHANGE_EN
  localparam state_t PURCH_EXIT = REFUND;
`else
  localparam state_t PURCH_EXIT = MONEY;
`endif

  state_t      state_q, state_d;
  logic [4:0]  credit_q, credit_d;
  logic        vend_q, vend_d;
  logic [1:0]  vend_type_q, vend_type_d;
  logic        change_q, change_d;
  logic        reject_q, reject_d;

  logic              hold_load;
  logic [HOLD_W-1:0] hold_val;
  logic              hold_done;

  logic [4:0] coin_add;
  logic [4:0] price;
  logic       purchase;
  logic       pay;
  logic [4:0] base;
  logic [5:0] sum6;
  logic       coin_state;
  logic       coin_ok;

  hold_timer #(.W(HOLD_W)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hold_load),
    .count (hold_val),
    .done  (hold_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      credit_q    <= '0;
      vend_q      <= 1'b0;
      vend_type_q <= '0;
      change_q    <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      vend_q      <= vend_d;
      vend_type_q <= vend_type_d;
      change_q    <= change_d;
      reject_q    <= reject_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    vend_d      = 1'b0;
    vend_type_d = vend_type_q;
    change_d    = 1'b0;
    reject_d    = 1'b0;
    hold_load   = 1'b0;
    hold_val    = '0;

    coin_add = (nickel ? NICKEL_U : 5'd0) + (dime ? DIME_U : 5'd0);
    price    = price_u(cost);

    // Affordability uses the credit before this cycle's coins.
    purchase = (state_q == MONEY) && !refund_req && sel_valid && (credit_q >= price);
    pay      = (state_q == REFUND) && change_q && coin_ready && (credit_q != 5'd0);

    if (purchase) begin
      base = credit_q - price;
    end else if (pay) begin
      base = credit_q - 5'd1;
    end else begin
      base = credit_q;
    end

    // Overflow is judged on the credit after any deduction this cycle, and
    // rejects the whole cycle's coins together.
    sum6       = {1'b0, base} + {1'b0, coin_add};
    coin_state = (state_q == INIT) || (state_q == MONEY) ||
                 (state_q == PURCHASED) || (state_q == REJECTION);
    coin_ok    = coin_state && (coin_add != 5'd0) && (sum6 <= {1'b0, CREDIT_MAX});
    credit_d   = coin_ok ? sum6[4:0] : base;
    reject_d   = (coin_add != 5'd0) && !coin_ok;

    case (state_q)
      INIT: begin
        if (sel_valid) begin
          state_d   = REJECTION;
          hold_load = 1'b1;
          hold_val  = REJ_LD;
        end else if (coin_ok) begin
          state_d = MONEY;
        end
      end
      MONEY: begin
        if (refund_req) begin
          state_d = REFUND;
        end else if (sel_valid) begin
          hold_load = 1'b1;
          if (purchase) begin
            state_d  = PURCHASED;
            hold_val = PURCH_LD;
          end else begin
            state_d  = REJECTION;
            hold_val = REJ_LD;
          end
        end
      end
      PURCHASED: begin
        if (hold_done) begin
          state_d = (credit_d != 5'd0) ? PURCH_EXIT : INIT;
        end
      end
      REJECTION: begin
        if (hold_done) begin
          state_d = (credit_d != 5'd0) ? MONEY : INIT;
        end
      end
      REFUND: begin
        // Credit already at zero here means the last nickel went out on the
        // previous edge; change_q is low this cycle.
        if (credit_q == 5'd0) begin
          state_d = INIT;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    change_d    = (state_d == REFUND) && (credit_d != 5'd0);
    vend_d      = purchase;
    vend_type_d = purchase ? foodtype : vend_type_q;
  end

  assign state         = state_q;
  assign credit        = credit_q;
  assign vend          = vend_q;
  assign vend_type     = vend_type_q;
  assign change_nickel = change_q;
  assign coin_reject   = reject_q;

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

  localparam int HOLD = 4;
`ifdef VEND_AUTO_CHANGE_EN
  localparam int AUTO_EXIT = 4;
`else
  localparam int AUTO_EXIT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nickel = 1'b0, dime = 1'b0, sel_valid = 1'b0;
  logic       refund_req = 1'b0, coin_ready = 1'b0;
  logic [1:0] cost = 2'd0, foodtype = 2'd0;
  logic [2:0] state;
  logic [4:0] credit;
  logic       vend;
  logic [1:0] vend_type;
  logic       change_nickel, coin_reject;

  vend_ctrl #(.PURCH_CYCLES(HOLD), .REJ_CYCLES(HOLD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .nickel        (nickel),
    .dime          (dime),
    .sel_valid     (sel_valid),
    .cost          (cost),
    .foodtype      (foodtype),
    .refund_req    (refund_req),
    .coin_ready    (coin_ready),
    .state         (state),
    .credit        (credit),
    .vend          (vend),
    .vend_type     (vend_type),
    .change_nickel (change_nickel),
    .coin_reject   (coin_reject)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] cr;
    logic       v;
    logic [1:0] vt;
    logic       cn;
    logic       rej;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e, mon_a;
  int    errors = 0;
  int    checks = 0;
  int    nickels_paid = 0;

  // Reference model: state, credit, remaining hold cycles, last foodtype.
  int m_st = 0, m_cr = 0, m_hold = 0, m_vt = 0;
  bit m_cn = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Advance the model by one clock given this cycle's inputs and queue the
  // outputs expected right after the edge.
  task automatic model_step(input bit n, input bit d, input bit sv, input int c,
                            input int f, input bit rr, input bit rdy);
    int add, price, ncr, nst;
    bit rej, v;
    snap_t e;
    add   = (n ? 1 : 0) + (d ? 2 : 0);
    price = 5 * (c + 1);
    ncr   = m_cr;
    nst   = m_st;
    v     = 1'b0;
    rej   = 1'b0;
    if (m_st == 1 && !rr && sv && m_cr >= price) begin
      ncr  = m_cr - price;
      v    = 1'b1;
      m_vt = f;
    end
    if (m_st == 4 && m_cn && rdy) ncr = m_cr - 1;
    if (add > 0) begin
      if (m_st == 4 || ncr + add > 31) rej = 1'b1;
      else ncr = ncr + add;
    end
    case (m_st)
      0: if (sv) begin nst = 3; m_hold = HOLD; end
         else if (add > 0 && !rej) nst = 1;
      1: if (rr) nst = 4;
         else if (sv) begin nst = v ? 2 : 3; m_hold = HOLD; end
      2: if (m_hold == 1) nst = (ncr > 0) ? AUTO_EXIT : 0;
         else m_hold = m_hold - 1;
      3: if (m_hold == 1) nst = (ncr > 0) ? 1 : 0;
         else m_hold = m_hold - 1;
      4: if (m_cr == 0) nst = 0;
      default: nst = 0;
    endcase
    m_cn = (nst == 4) && (ncr > 0);
    m_st = nst;
    m_cr = ncr;
    e.st  = 3'(m_st);
    e.cr  = 5'(m_cr);
    e.v   = v;
    e.vt  = 2'(m_vt);
    e.cn  = m_cn;
    e.rej = rej;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit n, input bit d, input bit sv, input int c,
                     input int f, input bit rr, input bit rdy);
    @(negedge clk);
    nickel     = n;
    dime       = d;
    sel_valid  = sv;
    cost       = 2'(c);
    foodtype   = 2'(f);
    refund_req = rr;
    coin_ready = rdy;
    model_step(n, d, sv, c, f, rr, rdy);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic dimes(input int k);
    for (int i = 0; i < k; i++) cyc(0, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle so the outputs must clear without a clock edge.
  task automatic do_reset;
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    nickel     = 1'b0;
    dime       = 1'b0;
    sel_valid  = 1'b0;
    refund_req = 1'b0;
    coin_ready = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_credit", credit, 0);
    check("rst_vend", vend, 0);
    check("rst_vend_type", vend_type, 0);
    check("rst_change_nickel", change_nickel, 0);
    check("rst_coin_reject", coin_reject, 0);
    exp_q.delete();
    m_st = 0; m_cr = 0; m_hold = 0; m_vt = 0; m_cn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_state", state, 0);
  endtask

  always @(posedge clk) begin
    if (rst_n && change_nickel && coin_ready) nickels_paid++;
  end

  // Monitor: every clock the DUT presents a new snapshot; compare it with
  // the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        mon_e     = exp_q.pop_front();
        mon_a.st  = state;
        mon_a.cr  = credit;
        mon_a.v   = vend;
        mon_a.vt  = vend_type;
        mon_a.cn  = change_nickel;
        mon_a.rej = coin_reject;
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL snapshot @%0t: got st=%0d cr=%0d vend=%0d vt=%0d cn=%0d rej=%0d, expected st=%0d cr=%0d vend=%0d vt=%0d cn=%0d rej=%0d",
                   $time, mon_a.st, mon_a.cr, mon_a.v, mon_a.vt, mon_a.cn, mon_a.rej,
                   mon_e.st, mon_e.cr, mon_e.v, mon_e.vt, mon_e.cn, mon_e.rej);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit n, d, sv, rr, rdy;

    do_reset();

    // Purchase: 3 dimes, cost 0 (5 units), foodtype 2.
    dimes(3);
    cyc(0, 0, 1, 0, 2, 0, 1);
    settle();
    check("buy_state", state, 2);
    check("buy_credit", credit, 1);
    check("buy_vend", vend, 1);
    check("buy_vend_type", vend_type, 2);
    idle(4);
    settle();
    check("buy_exit_state", state, AUTO_EXIT);
    check("buy_exit_credit", credit, 1);
    idle(2);
    settle();
`ifdef VEND_AUTO_CHANGE_EN
    check("buy_after_state", state, 0);
    check("buy_after_credit", credit, 0);
`else
    check("buy_after_state", state, 1);
    check("buy_after_credit", credit, 1);
`endif
    check("vend_type_hold", vend_type, 2);

    // Rejection: 1 unit against a 10-unit item.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 1, 0, 1);
    settle();
    check("rej_state", state, 3);
    check("rej_credit", credit, 1);
    idle(4);
    settle();
    check("rej_exit_state", state, 1);
    check("rej_exit_credit", credit, 1);

    // Overflow: 30 + 3 rejected.
    do_reset();
    dimes(15);
    cyc(1, 1, 0, 0, 0, 0, 1);
    settle();
    check("ovf_coin_reject", coin_reject, 1);
    check("ovf_credit", credit, 30);

    // Exact fill to 31, then one more nickel rejected.
    do_reset();
    dimes(14);
    cyc(1, 0, 0, 0, 0, 0, 1);
    dimes(1);
    settle();
    check("fill_credit", credit, 31);
    check("fill_reject", coin_reject, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    settle();
    check("full_reject", coin_reject, 1);
    check("full_credit", credit, 31);

    // Refund with a stalling hopper.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    p0 = nickels_paid;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    settle();
    check("refund_nickels", nickels_paid - p0, 3);
    check("refund_credit", credit, 0);
    check("refund_state", state, 0);

    // Refund beats selection in the same cycle.
    do_reset();
    dimes(5);
    cyc(0, 0, 1, 0, 1, 1, 1);
    settle();
    check("prio_state", state, 4);
    check("prio_vend", vend, 0);
    idle(12);
    settle();
    check("prio_drain_state", state, 0);

    // Reset in the middle of a refund.
    do_reset();
    dimes(3);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("midref_state", state, 4);
    check("midref_credit", credit, 7);
    check("midref_change", change_nickel, 1);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 700; i++) begin
      n   = ($urandom % 4) == 0;
      d   = ($urandom % 4) == 0;
      sv  = ($urandom % 10) == 0;
      rr  = ($urandom % 14) == 0;
      rdy = ($urandom % 4) != 0;
      cyc(n, d, sv, int'($urandom % 4), int'($urandom % 4), rr, rdy);
      if (($urandom % 150) == 0) do_reset();
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
